// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory data port between the CPU (0) and debug/DMA (1).
// Optional saturating perf counters are built when MEM_PORT_ARBITER_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [14:0] addr0,
  input  logic [15:0] wdata0,
  input  logic        flush0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [14:0] addr1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic [14:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        mem_wen,
  output logic [14:0] mem_waddr,
  output logic [15:0] mem_wdata
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [15:0] perf_gnt0,
  output logic [15:0] perf_gnt1,
  output logic [15:0] perf_conflict
`endif
);

  typedef enum logic {PTR_REQ0 = 1'b0, PTR_REQ1 = 1'b1} ptr_e;

  ptr_e                ptr_q;
  logic [READ_LAT-1:0] tvld_q;
  logic [READ_LAT-1:0] tid_q;
  logic [14:0]         raddr_q;
  logic [15:0]         rdata0_q;
  logic [15:0]         rdata1_q;
  logic                elig0, elig1;
  logic                rd_acc, wr_acc, out_vld;

  always_comb begin
    // Gating eligibility with reset keeps grants and writes quiet in the reset cycle.
    elig0     = req0 & ~flush0 & ~reset;
    elig1     = req1 & ~reset;
    gnt0      = elig0 & (~elig1 | (ptr_q == PTR_REQ0));
    gnt1      = elig1 & (~elig0 | (ptr_q == PTR_REQ1));
    rd_acc    = (gnt0 & ~we0) | (gnt1 & ~we1);
    wr_acc    = (gnt0 & we0) | (gnt1 & we1);
    mem_raddr = rd_acc ? (gnt1 ? addr1 : addr0) : raddr_q;
    mem_wen   = wr_acc;
    mem_waddr = gnt1 ? addr1 : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    out_vld   = tvld_q[READ_LAT-1] & ~reset;
    // A flush also kills a requester-0 tag sitting at the output stage this cycle.
    rvalid0   = out_vld & ~tid_q[READ_LAT-1] & ~flush0;
    rvalid1   = out_vld & tid_q[READ_LAT-1];
    rdata0    = reset ? '0 : (rvalid0 ? mem_rdata : rdata0_q);
    rdata1    = reset ? '0 : (rvalid1 ? mem_rdata : rdata1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= PTR_REQ0;
      tvld_q   <= '0;
      tid_q    <= '0;
      raddr_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (gnt0)
        ptr_q <= PTR_REQ1;
      else if (gnt1)
        ptr_q <= PTR_REQ0;
      raddr_q <= mem_raddr;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tvld_q[i] <= tvld_q[i-1] & ~(flush0 & ~tid_q[i-1]);
        tid_q[i]  <= tid_q[i-1];
      end
      tvld_q[0] <= rd_acc;
      tid_q[0]  <= gnt1;
      if (rvalid0)
        rdata0_q <= mem_rdata;
      if (rvalid1)
        rdata1_q <= mem_rdata;
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] pg0_q, pg1_q, pcf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pcf_q <= '0;
    end else begin
      if (gnt0 && pg0_q != '1)
        pg0_q <= pg0_q + 16'd1;
      if (gnt1 && pg1_q != '1)
        pg1_q <= pg1_q + 16'd1;
      if (elig0 && elig1 && pcf_q != '1)
        pcf_q <= pcf_q + 16'd1;
    end
  end

  assign perf_gnt0     = pg0_q;
  assign perf_gnt1     = pg1_q;
  assign perf_conflict = pcf_q;
`endif

endmodule
